// File: rtl/sbinit_sb_msg_arbiter_if.sv
// Handshake bundle between the SBINIT TX/RX sub-FSMs, the message arbiter and the SB encoder.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface sbinit_sb_msg_arbiter_if #(
   parameter int unsigned SB_MSG_WIDTH = 4
);
   logic                    i_SBINIT_en;
   logic                    i_valid_tx;
   logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg_tx;
   logic                    i_valid_rx;
   logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg_rx;
   logic                    i_SB_Busy;
   logic                    o_msg_valid;
   logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg;
   logic                    o_msg_src;
   logic                    o_tx_valid;
   logic                    o_falling_edge_busy;
   logic                    o_tx_done;
   logic                    o_rx_done;
   logic                    o_timeout;

   modport master (
      input  i_SBINIT_en, i_valid_tx, i_encoded_SB_msg_tx, i_valid_rx, i_encoded_SB_msg_rx,
      input  i_SB_Busy,
      output o_msg_valid, o_encoded_SB_msg, o_msg_src, o_tx_valid, o_falling_edge_busy,
      output o_tx_done, o_rx_done, o_timeout
   );

   modport slave (
      output i_SBINIT_en, i_valid_tx, i_encoded_SB_msg_tx, i_valid_rx, i_encoded_SB_msg_rx,
      output i_SB_Busy,
      input  o_msg_valid, o_encoded_SB_msg, o_msg_src, o_tx_valid, o_falling_edge_busy,
      input  o_tx_done, o_rx_done, o_timeout
   );
endinterface

// File: rtl/sbinit_sb_msg_arbiter.sv
// Round-robin arbiter granting the SB encoder to the SBINIT TX or RX sub-FSM, holding the
// granted message until the SB has serialised it, with a watchdog on SB acceptance.
module sbinit_sb_msg_arbiter #(
   parameter int unsigned SB_MSG_WIDTH   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_WIDTH      = 11
) (
   input logic                     i_clk,
   input logic                     i_rst,
   sbinit_sb_msg_arbiter_if.master bus
);

   localparam logic [1:0] StIdle        = 2'd0;
   localparam logic [1:0] StIssue       = 2'd1;
   localparam logic [1:0] StWaitBusyLow = 2'd2;

   localparam logic [CNT_WIDTH-1:0] WdLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]              state_q, state_d;
   logic [CNT_WIDTH-1:0]    wd_q, wd_d;
   logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
   logic                    valid_q, valid_d;
   logic                    src_q, src_d;
   logic                    last_q, last_d;
   logic                    guard_q, guard_d;
   logic                    busy_q;
   logic                    tx_done_q, tx_done_d;
   logic                    rx_done_q, rx_done_d;
   logic                    timeout_q, timeout_d;

   logic falling;
   logic req;
   logic grant_src;

   assign falling   = busy_q & ~bus.i_SB_Busy;
   assign req       = (bus.i_valid_tx | bus.i_valid_rx) & ~bus.i_SB_Busy & ~guard_q;
   // On a tie the source opposite the previous grant wins.
   assign grant_src = (bus.i_valid_tx & bus.i_valid_rx) ? ~last_q : bus.i_valid_rx;

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      msg_d     = msg_q;
      valid_d   = valid_q;
      src_d     = src_q;
      last_d    = last_q;
      guard_d   = guard_q;
      tx_done_d = 1'b0;
      rx_done_d = 1'b0;
      timeout_d = 1'b0;
      if (!bus.i_SBINIT_en) begin
         state_d = StIdle;
         wd_d    = '0;
         msg_d   = '0;
         valid_d = 1'b0;
         src_d   = 1'b0;
         guard_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               guard_d = 1'b0;
               if (req) begin
                  state_d = StIssue;
                  wd_d    = '0;
                  msg_d   = grant_src ? bus.i_encoded_SB_msg_rx : bus.i_encoded_SB_msg_tx;
                  valid_d = 1'b1;
                  src_d   = grant_src;
                  last_d  = grant_src;
               end else begin
                  msg_d = '0;
                  src_d = 1'b0;
               end
            end
            StIssue: begin
               wd_d = wd_q + CNT_WIDTH'(1);
               // Busy rising takes priority over a coincident watchdog expiry.
               if (bus.i_SB_Busy) begin
                  state_d = StWaitBusyLow;
                  valid_d = 1'b0;
               end else if (wd_q == WdLast) begin
                  state_d   = StIdle;
                  valid_d   = 1'b0;
                  timeout_d = 1'b1;
                  guard_d   = 1'b1;
               end
            end
            StWaitBusyLow: begin
               if (falling) begin
                  state_d   = StIdle;
                  tx_done_d = ~src_q;
                  rx_done_d = src_q;
                  guard_d   = 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         wd_q      <= '0;
         msg_q     <= '0;
         valid_q   <= 1'b0;
         src_q     <= 1'b0;
         last_q    <= 1'b1;
         guard_q   <= 1'b0;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
         rx_done_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         msg_q     <= msg_d;
         valid_q   <= valid_d;
         src_q     <= src_d;
         last_q    <= last_d;
         guard_q   <= guard_d;
         busy_q    <= bus.i_SB_Busy;
         tx_done_q <= tx_done_d;
         rx_done_q <= rx_done_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.o_msg_valid         = valid_q;
   assign bus.o_encoded_SB_msg    = msg_q;
   assign bus.o_msg_src           = src_q;
   assign bus.o_tx_valid          = bus.i_valid_tx | ((state_q != StIdle) & ~src_q);
   assign bus.o_falling_edge_busy = falling;
   assign bus.o_tx_done           = tx_done_q;
   assign bus.o_rx_done           = rx_done_q;
   assign bus.o_timeout           = timeout_q;

endmodule

// File: tb/tb_sbinit_sb_msg_arbiter.sv
// Bench for the SBINIT SB message arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_sbinit_sb_msg_arbiter;
   localparam int unsigned W  = 4;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errs = 0;

   sbinit_sb_msg_arbiter_if #(.SB_MSG_WIDTH(W)) bus ();

   sbinit_sb_msg_arbiter #(
      .SB_MSG_WIDTH  (W),
      .TIMEOUT_CYCLES(TO),
      .CNT_WIDTH     (5)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] outs();
      return {bus.o_msg_valid, bus.o_encoded_SB_msg, bus.o_msg_src, bus.o_tx_valid,
              bus.o_falling_edge_busy, bus.o_tx_done, bus.o_rx_done, bus.o_timeout};
   endfunction

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_idle();
      bus.i_SBINIT_en         = 1'b0;
      bus.i_valid_tx          = 1'b0;
      bus.i_encoded_SB_msg_tx = '0;
      bus.i_valid_rx          = 1'b0;
      bus.i_encoded_SB_msg_rx = '0;
      bus.i_SB_Busy           = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      nclk(2);
      rst = 1'b0;
      bus.i_SBINIT_en = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      #1;
      checks++;
      if (outs() !== 11'd0) begin
         errs++; $display("FAIL reset_hold outs=%b want 0", outs());
      end
      nclk(2);
      rst = 1'b0;
      bus.i_SBINIT_en = 1'b1;
      nclk(1);
      checks++;
      if (outs() !== 11'd0) begin
         errs++; $display("FAIL reset_idle outs=%b want 0", outs());
      end
   endtask

   task automatic test_rx_single();
      do_reset();
      bus.i_valid_rx = 1'b1; bus.i_encoded_SB_msg_rx = 4'd2;
      nclk(1);
      checks++;
      if (bus.o_msg_valid !== 1'b1 || bus.o_encoded_SB_msg !== 4'd2 || bus.o_msg_src !== 1'b1) begin
         errs++; $display("FAIL rx_grant v/msg/src=%b/%0d/%b want 1/2/1",
                          bus.o_msg_valid, bus.o_encoded_SB_msg, bus.o_msg_src);
      end
      bus.i_SB_Busy = 1'b1;
      nclk(1);
      checks++;
      if (bus.o_msg_valid !== 1'b0 || bus.o_encoded_SB_msg !== 4'd2) begin
         errs++; $display("FAIL rx_hold v/msg=%b/%0d want 0/2", bus.o_msg_valid, bus.o_encoded_SB_msg);
      end
      nclk(2);
      bus.i_SB_Busy = 1'b0;
      #1;
      checks++;
      if (bus.o_falling_edge_busy !== 1'b1) begin
         errs++; $display("FAIL rx_fall got %b want 1", bus.o_falling_edge_busy);
      end
      nclk(1);
      checks++;
      if (bus.o_rx_done !== 1'b1 || bus.o_tx_done !== 1'b0 || bus.o_msg_valid !== 1'b0 ||
          bus.o_falling_edge_busy !== 1'b0) begin
         errs++; $display("FAIL rx_done rx/tx/v/fall=%b/%b/%b/%b want 1/0/0/0", bus.o_rx_done,
                          bus.o_tx_done, bus.o_msg_valid, bus.o_falling_edge_busy);
      end
      bus.i_valid_rx = 1'b0;
      nclk(1);
      checks++;
      if (bus.o_rx_done !== 1'b0 || bus.o_encoded_SB_msg !== 4'd0) begin
         errs++; $display("FAIL rx_after done/msg=%b/%0d want 0/0", bus.o_rx_done, bus.o_encoded_SB_msg);
      end
   endtask

   task automatic test_tie();
      do_reset();
      bus.i_valid_tx = 1'b1; bus.i_encoded_SB_msg_tx = 4'd1;
      bus.i_valid_rx = 1'b1; bus.i_encoded_SB_msg_rx = 4'd2;
      #1;
      checks++;
      if (bus.o_tx_valid !== 1'b1) begin
         errs++; $display("FAIL tie_txv0 got %b want 1", bus.o_tx_valid);
      end
      nclk(1);
      checks++;
      if (bus.o_msg_valid !== 1'b1 || bus.o_encoded_SB_msg !== 4'd1 || bus.o_msg_src !== 1'b0 ||
          bus.o_tx_valid !== 1'b1) begin
         errs++; $display("FAIL tie_first v/msg/src/txv=%b/%0d/%b/%b want 1/1/0/1", bus.o_msg_valid,
                          bus.o_encoded_SB_msg, bus.o_msg_src, bus.o_tx_valid);
      end
      bus.i_SB_Busy = 1'b1;
      nclk(1);
      bus.i_SB_Busy = 1'b0;
      nclk(1);
      checks++;
      if (bus.o_tx_done !== 1'b1 || bus.o_tx_valid !== 1'b1) begin
         errs++; $display("FAIL tie_txdone done/txv=%b/%b want 1/1", bus.o_tx_done, bus.o_tx_valid);
      end
      bus.i_valid_tx = 1'b0;
      nclk(1);
      checks++;
      if (bus.o_msg_valid !== 1'b0) begin
         errs++; $display("FAIL tie_guard v=%b want 0", bus.o_msg_valid);
      end
      bus.i_valid_tx = 1'b1; bus.i_encoded_SB_msg_tx = 4'd5;
      nclk(1);
      checks++;
      if (bus.o_msg_valid !== 1'b1 || bus.o_encoded_SB_msg !== 4'd2 || bus.o_msg_src !== 1'b1) begin
         errs++; $display("FAIL tie_second v/msg/src=%b/%0d/%b want 1/2/1", bus.o_msg_valid,
                          bus.o_encoded_SB_msg, bus.o_msg_src);
      end
      bus.i_SB_Busy = 1'b1;
      nclk(1);
      bus.i_SB_Busy = 1'b0;
      nclk(1);
      checks++;
      if (bus.o_rx_done !== 1'b1) begin
         errs++; $display("FAIL tie_rxdone got %b want 1", bus.o_rx_done);
      end
      bus.i_valid_rx = 1'b0;
      nclk(2);
      checks++;
      if (bus.o_msg_valid !== 1'b1 || bus.o_encoded_SB_msg !== 4'd5 || bus.o_msg_src !== 1'b0) begin
         errs++; $display("FAIL tie_third v/msg/src=%b/%0d/%b want 1/5/0", bus.o_msg_valid,
                          bus.o_encoded_SB_msg, bus.o_msg_src);
      end
   endtask

   task automatic test_ext_busy();
      do_reset();
      bus.i_SB_Busy = 1'b1;
      bus.i_valid_tx = 1'b1; bus.i_encoded_SB_msg_tx = 4'd7;
      nclk(2);
      checks++;
      if (bus.o_msg_valid !== 1'b0) begin
         errs++; $display("FAIL ext_nogrant v=%b want 0", bus.o_msg_valid);
      end
      bus.i_SB_Busy = 1'b0;
      #1;
      checks++;
      if (bus.o_falling_edge_busy !== 1'b1) begin
         errs++; $display("FAIL ext_fall got %b want 1", bus.o_falling_edge_busy);
      end
      nclk(1);
      checks++;
      if (bus.o_msg_valid !== 1'b1 || bus.o_encoded_SB_msg !== 4'd7 || bus.o_msg_src !== 1'b0) begin
         errs++; $display("FAIL ext_grant v/msg/src=%b/%0d/%b want 1/7/0", bus.o_msg_valid,
                          bus.o_encoded_SB_msg, bus.o_msg_src);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      bus.i_valid_tx = 1'b1; bus.i_encoded_SB_msg_tx = 4'd9;
      nclk(1);
      checks++;
      if (bus.o_msg_valid !== 1'b1) begin
         errs++; $display("FAIL to_grant v=%b want 1", bus.o_msg_valid);
      end
      for (int i = 1; i < int'(TO); i++) begin
         nclk(1);
         checks++;
         if (bus.o_msg_valid !== 1'b1 || bus.o_timeout !== 1'b0) begin
            errs++; $display("FAIL to_wait cycle %0d v/to=%b/%b want 1/0", i, bus.o_msg_valid,
                             bus.o_timeout);
         end
      end
      nclk(1);
      checks++;
      if (bus.o_timeout !== 1'b1 || bus.o_msg_valid !== 1'b0 || bus.o_tx_done !== 1'b0 ||
          bus.o_rx_done !== 1'b0) begin
         errs++; $display("FAIL to_fire to/v/txd/rxd=%b/%b/%b/%b want 1/0/0/0", bus.o_timeout,
                          bus.o_msg_valid, bus.o_tx_done, bus.o_rx_done);
      end
      bus.i_valid_tx = 1'b0;
      nclk(1);
      checks++;
      if (bus.o_timeout !== 1'b0 || bus.o_encoded_SB_msg !== 4'd0 || bus.o_msg_valid !== 1'b0) begin
         errs++; $display("FAIL to_after to/msg/v=%b/%0d/%b want 0/0/0", bus.o_timeout,
                          bus.o_encoded_SB_msg, bus.o_msg_valid);
      end
   endtask

   task automatic test_enable_drop();
      do_reset();
      bus.i_valid_rx = 1'b1; bus.i_encoded_SB_msg_rx = 4'd3;
      nclk(1);
      bus.i_SBINIT_en = 1'b0;
      nclk(1);
      checks++;
      if (outs() !== 11'd0) begin
         errs++; $display("FAIL en_issue outs=%b want 0", outs());
      end
      bus.i_SBINIT_en = 1'b1;
      nclk(1);
      checks++;
      if (bus.o_msg_valid !== 1'b1 || bus.o_encoded_SB_msg !== 4'd3 || bus.o_msg_src !== 1'b1) begin
         errs++; $display("FAIL en_regrant v/msg/src=%b/%0d/%b want 1/3/1", bus.o_msg_valid,
                          bus.o_encoded_SB_msg, bus.o_msg_src);
      end
      bus.i_SB_Busy = 1'b1;
      nclk(1);
      bus.i_SBINIT_en = 1'b0;
      nclk(1);
      checks++;
      if (outs() !== 11'd0) begin
         errs++; $display("FAIL en_wait outs=%b want 0", outs());
      end
      bus.i_SB_Busy = 1'b0;
      bus.i_valid_rx = 1'b0;
      #1;
      checks++;
      if (bus.o_falling_edge_busy !== 1'b1) begin
         errs++; $display("FAIL en_fall got %b want 1", bus.o_falling_edge_busy);
      end
      nclk(1);
      checks++;
      if (outs() !== 11'd0) begin
         errs++; $display("FAIL en_nopulse outs=%b want 0", outs());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.i_valid_tx = 1'b1; bus.i_encoded_SB_msg_tx = 4'd4;
      nclk(1);
      bus.i_SB_Busy = 1'b1;
      nclk(1);
      checks++;
      if (bus.o_encoded_SB_msg !== 4'd4 || bus.o_msg_valid !== 1'b0) begin
         errs++; $display("FAIL rm_wait msg/v=%0d/%b want 4/0", bus.o_encoded_SB_msg, bus.o_msg_valid);
      end
      #2;
      drive_idle();
      rst = 1'b1;
      #1;
      checks++;
      if (outs() !== 11'd0) begin
         errs++; $display("FAIL rm_async outs=%b want 0", outs());
      end
      nclk(2);
      rst = 1'b0;
      bus.i_SBINIT_en = 1'b1;
      bus.i_valid_tx = 1'b1; bus.i_encoded_SB_msg_tx = 4'd1;
      bus.i_valid_rx = 1'b1; bus.i_encoded_SB_msg_rx = 4'd2;
      nclk(1);
      checks++;
      if (bus.o_msg_valid !== 1'b1 || bus.o_encoded_SB_msg !== 4'd1 || bus.o_msg_src !== 1'b0) begin
         errs++; $display("FAIL rm_tie v/msg/src=%b/%0d/%b want 1/1/0", bus.o_msg_valid,
                          bus.o_encoded_SB_msg, bus.o_msg_src);
      end
   endtask

   // Randomized requesters and SB responder; the model tracks ownership and round-robin order.
   task automatic test_random();
      int       tx_wait = 0;
      int       rx_wait = 0;
      int       rsp = 0;
      int       rsp_cnt = 0;
      int       grants = 0;
      logic     model_last = 1'b1;
      logic     arb_busy = 1'b0;
      logic     cur_src = 1'b0;
      logic     pend = 1'b0;
      logic     exp_src = 1'b0;
      logic [3:0] exp_msg = '0;
      logic     exp_done = 1'b0;
      logic     guard = 1'b0;
      logic     prev_busy = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         nclk(1);
         checks++;
         if (pend) begin
            if (bus.o_msg_valid !== 1'b1 || bus.o_msg_src !== exp_src ||
                bus.o_encoded_SB_msg !== exp_msg) begin
               errs++; $display("FAIL rand_grant cyc %0d v/src/msg=%b/%b/%0d want 1/%b/%0d", cyc,
                                bus.o_msg_valid, bus.o_msg_src, bus.o_encoded_SB_msg, exp_src, exp_msg);
            end
            arb_busy = 1'b1; cur_src = exp_src; model_last = exp_src; grants++;
         end else if (!arb_busy && bus.o_msg_valid !== 1'b0) begin
            errs++; $display("FAIL rand_spurious cyc %0d v=%b want 0", cyc, bus.o_msg_valid);
         end
         checks++;
         if (bus.o_tx_done !== (exp_done & ~cur_src) || bus.o_rx_done !== (exp_done & cur_src) ||
             bus.o_timeout !== 1'b0) begin
            errs++; $display("FAIL rand_done cyc %0d txd/rxd/to=%b/%b/%b want %b/%b/0", cyc,
                             bus.o_tx_done, bus.o_rx_done, bus.o_timeout, exp_done & ~cur_src,
                             exp_done & cur_src);
         end
         guard = exp_done;
         if (exp_done) begin
            arb_busy = 1'b0;
            if (cur_src) begin
               bus.i_valid_rx = 1'b0; rx_wait = $urandom_range(1, 3);
            end else begin
               bus.i_valid_tx = 1'b0; tx_wait = $urandom_range(1, 3);
            end
         end
         exp_done = 1'b0;
         prev_busy = bus.i_SB_Busy;
         if (rsp == 0 && bus.o_msg_valid === 1'b1) begin
            rsp = 1; rsp_cnt = $urandom_range(0, 3);
         end
         if (rsp == 1) begin
            if (rsp_cnt == 0) begin
               bus.i_SB_Busy = 1'b1; rsp = 2; rsp_cnt = $urandom_range(1, 4);
            end else begin
               rsp_cnt--;
            end
         end else if (rsp == 2) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               bus.i_SB_Busy = 1'b0; rsp = 0; exp_done = 1'b1;
            end
         end
         if (!bus.i_valid_tx) begin
            if (tx_wait > 0) tx_wait--;
            else if ($urandom_range(0, 1) == 1) begin
               bus.i_valid_tx = 1'b1; bus.i_encoded_SB_msg_tx = 4'($urandom_range(0, 15));
            end
         end
         if (!bus.i_valid_rx) begin
            if (rx_wait > 0) rx_wait--;
            else if ($urandom_range(0, 1) == 1) begin
               bus.i_valid_rx = 1'b1; bus.i_encoded_SB_msg_rx = 4'($urandom_range(0, 15));
            end
         end
         #1;
         checks++;
         if (bus.o_falling_edge_busy !== (prev_busy & ~bus.i_SB_Busy) ||
             bus.o_tx_valid !== (bus.i_valid_tx | (arb_busy & ~cur_src))) begin
            errs++; $display("FAIL rand_comb cyc %0d fall/txv=%b/%b want %b/%b", cyc,
                             bus.o_falling_edge_busy, bus.o_tx_valid, prev_busy & ~bus.i_SB_Busy,
                             bus.i_valid_tx | (arb_busy & ~cur_src));
         end
         pend = !arb_busy && !guard && !bus.i_SB_Busy && (bus.i_valid_tx || bus.i_valid_rx);
         if (pend) begin
            exp_src = (bus.i_valid_tx && bus.i_valid_rx) ? ~model_last : bus.i_valid_rx;
            exp_msg = exp_src ? bus.i_encoded_SB_msg_rx : bus.i_encoded_SB_msg_tx;
         end
      end
      checks++;
      if (grants < 20) begin
         errs++; $display("FAIL rand_grants got %0d want >= 20", grants);
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_rx_single();
      test_tie();
      test_ext_busy();
      test_timeout();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
      $finish;
   end

endmodule

// File: doc/sbinit_sb_msg_arbiter.md
Name: sbinit_sb_msg_arbiter

Overview:
Downstream stage of the SBINIT TX and RX sub-FSMs. It takes the encoded-message/valid pairs from both sub-FSMs and grants the sideband (SB) encoder to one of them at a time, round-robin. It holds the granted message stable until the SB has consumed it. It generates the busy falling-edge pulse and the tx-valid indication that both sub-FSMs use to drop or defer their valids. A watchdog flags an SB that never accepts a message.

Parameters:
SB_MSG_WIDTH, 4, width of encoded SB message field
TIMEOUT_CYCLES, 1024, cycles a message may wait in ISSUE for SB busy to rise before timeout
CNT_WIDTH, 11, width of watchdog counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous, active-high reset
i_SBINIT_en  input  1  SBINIT phase enable from LTSM
i_valid_tx  input  1  TX sub-FSM has a message
i_encoded_SB_msg_tx  input  SB_MSG_WIDTH  TX message code
i_valid_rx  input  1  RX sub-FSM has a message
i_encoded_SB_msg_rx  input  SB_MSG_WIDTH  RX message code
i_SB_Busy  input  1  SB encoder is serialising a message
o_msg_valid  output  1  message valid to SB encoder
o_encoded_SB_msg  output  SB_MSG_WIDTH  granted message code to SB encoder
o_msg_src  output  1  source of current grant: 0=TX, 1=RX
o_tx_valid  output  1  TX owns the SB, or is about to (to RX sub-FSM)
o_falling_edge_busy  output  1  one-cycle pulse on i_SB_Busy 1->0 (to both sub-FSMs)
o_tx_done  output  1  one-cycle pulse: TX message fully sent
o_rx_done  output  1  one-cycle pulse: RX message fully sent
o_timeout  output  1  one-cycle pulse: watchdog expired

Behaviour:
- Reset:
  - All outputs 0; state IDLE; watchdog 0; busy_d 0; last_grant=RX, so TX wins the first tie; guard flag 0.
  - Reset asserted in any state returns to IDLE immediately; o_msg_valid drops asynchronously.
- o_falling_edge_busy = busy_d & ~i_SB_Busy. busy_d is i_SB_Busy registered. The pulse is combinational, one cycle, and is generated in every state.
- o_tx_valid = i_valid_tx | (state != IDLE && o_msg_src == 0).
- States: IDLE, ISSUE, WAIT_BUSY_LOW.
- IDLE:
  - Grant is evaluated only when i_SBINIT_en=1, i_SB_Busy=0, guard=0, and at least one valid is high.
  - One requester: grant it. Both: grant the source opposite to last_grant.
  - On grant, at the next edge: latch the message into o_encoded_SB_msg, set o_msg_src and last_grant, set o_msg_valid=1, clear the watchdog, go to ISSUE.
  - Latency from request to o_msg_valid is 1 cycle.
- ISSUE:
  - o_msg_valid and o_encoded_SB_msg are held; input messages are ignored.
  - Watchdog increments each cycle.
  - i_SB_Busy=1: next edge o_msg_valid=0, go to WAIT_BUSY_LOW.
  - Watchdog reaches TIMEOUT_CYCLES-1 with busy still 0: next edge o_timeout=1 for one cycle, o_msg_valid=0, go to IDLE, guard=1. No done pulse is issued.
- WAIT_BUSY_LOW:
  - On o_falling_edge_busy: next edge pulse o_tx_done or o_rx_done per o_msg_src, go to IDLE, set guard=1.
- Guard clears after one IDLE cycle. It masks a requester's valid during the cycle in which that requester is still deasserting it.
- Requester valid dropping before grant: no grant, no side effect. Requester valid dropping after grant: ignored; the latched message still completes.
- i_SBINIT_en=0 in any state:
  - Next edge to IDLE; o_msg_valid, o_encoded_SB_msg, o_msg_src and the watchdog are cleared; no done/timeout pulse.
  - last_grant is kept.
- o_encoded_SB_msg returns to 0 in IDLE one cycle after done or timeout.
- Simultaneous i_SB_Busy rise and watchdog expiry in ISSUE: busy wins; no timeout.

Test Plan:
1. Reset, en=1, i_valid_rx=1 with msg=2, busy low. Required: o_msg_valid=1 and o_encoded_SB_msg=2, o_msg_src=1 one cycle later. Then busy high for 3 cycles then low. Required: o_falling_edge_busy pulse, then o_rx_done pulse, then o_msg_valid=0.
2. Both valids rise in the same cycle, tx msg=1, rx msg=2. Required: TX granted first (msg 1), and o_tx_valid=1 throughout. After o_tx_done, RX granted (msg 2) two cycles later because of the guard. Repeating the tie grants RX first.
3. Request while i_SB_Busy=1 from an external owner. Required: no grant until busy low; grant one cycle later.
4. Grant, then busy never rises, TIMEOUT_CYCLES=16. Required: o_timeout pulse 16 cycles after o_msg_valid rose, o_msg_valid=0, no done pulse.
5. i_SBINIT_en dropped in ISSUE and in WAIT_BUSY_LOW. Required: IDLE next cycle, all outputs 0, no pulses.
6. Reset asserted mid-WAIT_BUSY_LOW. Required: immediate IDLE and all outputs 0. After release, first tie goes to TX.
